// File: rtl/multi_key_start.sv
// Multi-key start block: per-key sync/debounce/press detect, retriggerable LED hold,
// and one arbitrated start request. Optional long-press output: MULTI_KEY_START_LONG_PRESS_EN.
module multi_key_start #(
   parameter int N_KEYS          = 4,
   parameter int ID_W            = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int LONG_CYCLES     = 100000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] led_n,
   output logic              start_valid,
   output logic [ID_W-1:0]   start_id,
   input  logic              start_ready,
   output logic [7:0]        drop_cnt,
   output logic              long_valid,
   output logic [ID_W-1:0]   long_id
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

   logic [N_KEYS-1:0] sync1_q, ks_q;
   logic [N_KEYS-1:0] stable_q, stable_d;
   logic [N_KEYS-1:0] led_q, led_d;
   logic [N_KEYS-1:0] press;
   logic [DW-1:0]     deb_q  [N_KEYS];
   logic [DW-1:0]     deb_d  [N_KEYS];
   logic [HW-1:0]     hold_q [N_KEYS];
   logic [HW-1:0]     hold_d [N_KEYS];
   logic              valid_q, valid_d;
   logic [ID_W-1:0]   id_q, id_d, sel_id;
   logic [7:0]        drop_q, drop_d;
   logic [4:0]        n_press, drops;
   logic [9:0]        drop_sum;
   logic              load;

   // press[i] is combinational so the LED and request update on the same edge as stable.
   always_comb begin
      stable_d = stable_q;
      press    = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         deb_d[i] = '0;
         if (ks_q[i] != stable_q[i]) begin
            if (deb_q[i] == DEB_MAX) begin
               stable_d[i] = ks_q[i];
               press[i]    = ~ks_q[i];
            end else begin
               deb_d[i] = deb_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      led_d = led_q;
      for (int i = 0; i < N_KEYS; i++) begin
         hold_d[i] = hold_q[i];
         if (press[i]) begin
            led_d[i]  = 1'b0;
            hold_d[i] = HOLD_MAX;
         end else if (!led_q[i]) begin
            if (hold_q[i] == '0) led_d[i] = 1'b1;
            else                 hold_d[i] = hold_q[i] - 1'b1;
         end
      end
   end

   always_comb begin
      sel_id  = '0;
      n_press = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (press[i]) sel_id = ID_W'(i);
         n_press = n_press + 5'(press[i]);
      end
      load     = (!valid_q || start_ready) && (|press);
      valid_d  = load ? 1'b1 : (valid_q && !start_ready);
      id_d     = load ? sel_id : id_q;
      // Every press except the one loaded is a drop, saturating at 255.
      drops    = load ? (n_press - 5'd1) : n_press;
      drop_sum = 10'(drop_q) + 10'(drops);
      drop_d   = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '1;
         ks_q     <= '1;
         stable_q <= '1;
         led_q    <= '1;
         valid_q  <= 1'b0;
         id_q     <= '0;
         drop_q   <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            deb_q[i]  <= '0;
            hold_q[i] <= '0;
         end
      end else begin
         sync1_q  <= key_n;
         ks_q     <= sync1_q;
         stable_q <= stable_d;
         led_q    <= led_d;
         valid_q  <= valid_d;
         id_q     <= id_d;
         drop_q   <= drop_d;
         for (int i = 0; i < N_KEYS; i++) begin
            deb_q[i]  <= deb_d[i];
            hold_q[i] <= hold_d[i];
         end
      end
   end

   assign led_n       = led_q;
   assign start_valid = valid_q;
   assign start_id    = id_q;
   assign drop_cnt    = drop_q;

`ifdef MULTI_KEY_START_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

   logic [LW-1:0]     lcnt_q [N_KEYS];
   logic [LW-1:0]     lcnt_d [N_KEYS];
   logic [N_KEYS-1:0] ldone_q, ldone_d, lhit;
   logic              lvalid_q, lvalid_d;
   logic [ID_W-1:0]   lid_q, lid_d;

   // ldone keeps the pulse to one per press; cleared again on release.
   always_comb begin
      ldone_d  = ldone_q;
      lhit     = '0;
      lid_d    = lid_q;
      for (int i = 0; i < N_KEYS; i++) begin
         lcnt_d[i] = lcnt_q[i];
         if (stable_q[i]) begin
            lcnt_d[i]  = '0;
            ldone_d[i] = 1'b0;
         end else if (!ldone_q[i]) begin
            if (lcnt_q[i] == LONG_MAX) begin
               lhit[i]    = 1'b1;
               ldone_d[i] = 1'b1;
            end else begin
               lcnt_d[i] = lcnt_q[i] + 1'b1;
            end
         end
      end
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (lhit[i]) lid_d = ID_W'(i);
      end
      lvalid_d = |lhit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ldone_q  <= '0;
         lvalid_q <= 1'b0;
         lid_q    <= '0;
         for (int i = 0; i < N_KEYS; i++) lcnt_q[i] <= '0;
      end else begin
         ldone_q  <= ldone_d;
         lvalid_q <= lvalid_d;
         lid_q    <= lid_d;
         for (int i = 0; i < N_KEYS; i++) lcnt_q[i] <= lcnt_d[i];
      end
   end

   assign long_valid = lvalid_q;
   assign long_id    = lid_q;
`else
   // LONG_CYCLES only sizes the long-press counters, which this build omits.
   if (LONG_CYCLES < 1) begin : g_long_unused
   end
   assign long_valid = 1'b0;
   assign long_id    = '0;
`endif

endmodule

// File: tb/tb_multi_key_start.sv
// Bench for multi_key_start: reset, table of single/simultaneous presses, LED timing,
// glitch rejection, retrigger, backpressure, drop saturation and the long-press output.
module tb_multi_key_start;

   localparam int N_KEYS = 4;
   localparam int ID_W   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N_KEYS-1:0] key_n;
   logic [N_KEYS-1:0] led_n;
   logic              start_valid;
   logic [ID_W-1:0]   start_id;
   logic              start_ready;
   logic [7:0]        drop_cnt;
   logic              long_valid;
   logic [ID_W-1:0]   long_id;

   always #5 clk = ~clk;

   multi_key_start #(
      .N_KEYS(N_KEYS), .ID_W(ID_W), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .LONG_CYCLES(20)
   ) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .led_n(led_n),
      .start_valid(start_valid), .start_id(start_id), .start_ready(start_ready),
      .drop_cnt(drop_cnt), .long_valid(long_valid), .long_id(long_id)
   );

   typedef struct {
      logic [3:0] keys;
      logic [1:0] id;
      logic [3:0] led;
      int         drops;
   } vec_t;

   int              n_checks = 0;
   int              n_fail   = 0;
   int              exp_drop = 0;
   int              long_pulses = 0;
   int              glitch_bad;
   int              lit;
   logic [ID_W-1:0] last_long_id = '0;
   logic [ID_W-1:0] exp_q[$];
   vec_t            vecs[4];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advances one edge; a handshake seen just before the edge is scored against exp_q.
   task automatic tick();
      logic            xfer;
      logic [ID_W-1:0] xid;
      xfer = start_valid && start_ready && !rst;
      xid  = start_id;
      @(posedge clk);
      #1;
      if (long_valid) begin
         long_pulses++;
         last_long_id = long_id;
      end
      if (xfer) begin
         if (exp_q.size() == 0) chk("unexpected_xfer", 1, 0);
         else                   chk("xfer_id", int'(xid), int'(exp_q.pop_front()));
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic sat_add(input int n);
      exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
   endtask

   task automatic press_vec(input vec_t v);
      key_n = v.keys;
      exp_q.push_back(v.id);
      sat_add(v.drops);
      ticks(5);
      chk("vec_pre_led", led_n, 4'hF);
      chk("vec_pre_valid", start_valid, 0);
      tick();
      chk("vec_led", led_n, v.led);
      chk("vec_valid", start_valid, 1);
      chk("vec_id", start_id, v.id);
      chk("vec_drop", drop_cnt, exp_drop);
      key_n = 4'hF;
      tick();
      chk("vec_valid_clr", start_valid, 0);
      ticks(20);
      chk("vec_led_off", led_n, 4'hF);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{keys: 4'b1011, id: 2'd2, led: 4'b1011, drops: 0};
      vecs[1] = '{keys: 4'b1110, id: 2'd0, led: 4'b1110, drops: 0};
      vecs[2] = '{keys: 4'b0111, id: 2'd3, led: 4'b0111, drops: 0};
      vecs[3] = '{keys: 4'b1010, id: 2'd0, led: 4'b1010, drops: 1};

      // Reset with all keys held: nothing until 6 edges after release of rst.
      rst = 1'b1; key_n = 4'b0000; start_ready = 1'b1;
      ticks(3);
      chk("rst_led", led_n, 4'hF);
      chk("rst_valid", start_valid, 0);
      chk("rst_id", start_id, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_long", long_valid, 0);
      rst = 1'b0;
      exp_q.push_back(2'd0);
      sat_add(3);
      ticks(5);
      chk("rst_no_early_led", led_n, 4'hF);
      chk("rst_no_early_valid", start_valid, 0);
      tick();
      chk("rst_evt_led", led_n, 4'b0000);
      chk("rst_evt_valid", start_valid, 1);
      chk("rst_evt_id", start_id, 0);
      chk("rst_evt_drop", drop_cnt, exp_drop);
      key_n = 4'hF;
      ticks(22);

      for (int i = 0; i < 4; i++) press_vec(vecs[i]);

      // Single press held: LED lit exactly 10 cycles, request for one cycle.
      key_n = 4'b1011;
      exp_q.push_back(2'd2);
      ticks(6);
      chk("single_led", led_n[2], 0);
      chk("single_id", start_id, 2);
      lit = 0;
      for (int k = 0; k < 40; k++) begin
         if (led_n[2]) break;
         lit++;
         tick();
         if (k == 0) chk("single_valid_one_cycle", start_valid, 0);
      end
      chk("single_lit_cycles", lit, 10);
      key_n = 4'hF;
      ticks(10);

      // Three-cycle glitch on key 1 is rejected.
      key_n = 4'b1101;
      ticks(3);
      key_n = 4'hF;
      glitch_bad = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (led_n != 4'hF || start_valid) glitch_bad++;
      end
      chk("glitch_no_event", glitch_bad, 0);
      chk("glitch_drop", drop_cnt, exp_drop);

      // Press, release, re-press as fast as debounce allows: LED retriggers.
      key_n = 4'b1101;
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd1);
      ticks(4);
      key_n = 4'hF;
      ticks(2);
      chk("retrig_first_led", led_n[1], 0);
      lit = 1;
      tick(); if (!led_n[1]) lit++;
      tick(); if (!led_n[1]) lit++;
      key_n = 4'b1101;
      for (int e = 9; e < 60; e++) begin
         tick();
         if (e == 14) chk("retrig_second_valid", start_valid, 1);
         if (led_n[1]) break;
         lit++;
      end
      chk("retrig_lit_cycles", lit, 18);
      key_n = 4'hF;
      ticks(12);

      // Backpressure: key 3 held pending, key 0 dropped, key 1 loads on the transfer edge.
      start_ready = 1'b0;
      key_n = 4'b0111;
      exp_q.push_back(2'd3);
      ticks(6);
      chk("bp_valid", start_valid, 1);
      chk("bp_id", start_id, 3);
      key_n = 4'b0110;
      sat_add(1);
      ticks(6);
      chk("bp_id_held", start_id, 3);
      chk("bp_drop", drop_cnt, exp_drop);
      key_n = 4'b0100;
      ticks(5);
      start_ready = 1'b1;
      exp_q.push_back(2'd1);
      tick();
      chk("bp_reload_valid", start_valid, 1);
      chk("bp_reload_id", start_id, 1);
      chk("bp_reload_drop", drop_cnt, exp_drop);
      tick();
      chk("bp_drain_valid", start_valid, 0);
      key_n = 4'hF;
      ticks(20);
      chk("bp_led_off", led_n, 4'hF);

      // All four keys pressed repeatedly while blocked: drop_cnt saturates.
      start_ready = 1'b0;
      exp_q.push_back(2'd0);
      for (int it = 0; it < 80; it++) begin
         key_n = 4'b0000;
         ticks(6);
         sat_add((it == 0) ? 3 : 4);
         if (it == 0) chk("sat_first_id", start_id, 0);
         if (it == 9) chk("sat_drop_mid", drop_cnt, exp_drop);
         key_n = 4'hF;
         ticks(6);
      end
      chk("sat_drop_255", drop_cnt, 255);
      start_ready = 1'b1;
      tick();
      chk("sat_drain_valid", start_valid, 0);
      ticks(10);

`ifdef MULTI_KEY_START_LONG_PRESS_EN
      long_pulses = 0;
      key_n = 4'b1101;
      exp_q.push_back(2'd1);
      ticks(40);
      key_n = 4'hF;
      ticks(12);
      chk("long_pulses", long_pulses, 1);
      chk("long_id", last_long_id, 1);
`else
      key_n = 4'b1101;
      exp_q.push_back(2'd1);
      ticks(40);
      key_n = 4'hF;
      ticks(12);
      chk("long_absent", long_pulses, 0);
`endif

      chk("exp_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
